vx_mem_responder: RTL



---
 rtl/vx_mem_responder_pkg.sv | 22 ++
 rtl/vx_mem_responder_rsp_fifo.sv | 84 ++++++++
 rtl/vx_mem_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vx_mem_responder_pkg.sv
// rtl/vx_mem_responder_pkg.sv - shared memory request/response field structs and latency limit
package VX_gpu_pkg;

    localparam int MEM_RSP_LATENCY_MAX = 8;
    localparam int MEM_DATA_SIZE       = 64;
    localparam int MEM_ADDR_WIDTH      = 10;
    localparam int MEM_TAG_WIDTH       = 8;

    typedef struct packed {
        logic                         rw;
        logic [MEM_ADDR_WIDTH-1:0]    addr;
        logic [MEM_DATA_SIZE-1:0]     byteen;
        logic [MEM_DATA_SIZE*8-1:0]   data;
        logic [MEM_TAG_WIDTH-1:0]     tag;
    } mem_req_t;

    typedef struct packed {
        logic [MEM_DATA_SIZE*8-1:0]   data;
        logic [MEM_TAG_WIDTH-1:0]     tag;
    } mem_rsp_t;

endpackage

// File: rtl/vx_mem_responder_rsp_fifo.sv
// rtl/vx_mem_responder_rsp_fifo.sv - response queue with a registered output head and full/empty flags
module vx_mem_responder_rsp_fifo
    import VX_gpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_tvalid,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    output logic [WIDTH-1:0] m_tdata,
    input  logic             m_tready,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] st_cnt_q, st_cnt_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             pop, load_out, st_wr, st_rd;

    // The output register is refilled from storage first so ordering holds; storage is bypassed only when empty.
    always_comb begin
        pop        = out_vld_q && m_tready;
        load_out   = !out_vld_q || pop;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        st_wr      = 1'b0;
        st_rd      = 1'b0;
        if (load_out) begin
            if (st_cnt_q != '0) begin
                st_rd      = 1'b1;
                out_vld_d  = 1'b1;
                out_data_d = store_q[rd_ptr_q];
                rd_ptr_d   = rd_ptr_q + 1'b1;
                st_wr      = s_tvalid;
            end else begin
                out_vld_d = s_tvalid;
                if (s_tvalid) begin
                    out_data_d = s_tdata;
                end
            end
        end else begin
            st_wr = s_tvalid;
        end
        if (st_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        st_cnt_d = st_cnt_q + CNT_W'(st_wr) - CNT_W'(st_rd);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            st_cnt_q  <= '0;
            out_vld_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            st_cnt_q  <= st_cnt_d;
            out_vld_q <= out_vld_d;
        end
        out_data_q <= out_data_d;
        if (st_wr) begin
            store_q[wr_ptr_q] <= s_tdata;
        end
    end

    assign m_tvalid = out_vld_q;
    assign m_tdata  = out_data_q;
    assign empty    = !out_vld_q;
    assign full     = out_vld_q && (st_cnt_q == CNT_W'(DEPTH - 1));

endmodule

// File: rtl/vx_mem_responder.sv
// rtl/vx_mem_responder.sv - byte-enabled line memory with pipelined, in-order tagged read responses
// Optional perf counters: define MEM_RESPONDER_PERF_EN.
module vx_mem_responder
    import VX_gpu_pkg::*;
#(
    parameter int DATA_SIZE  = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int TAG_WIDTH  = 8,
    parameter int LATENCY    = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_rw,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_SIZE-1:0]   req_byteen,
    input  logic [DATA_SIZE*8-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [DATA_SIZE*8-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    input  logic                   rsp_ready
`ifdef MEM_RESPONDER_PERF_EN
    ,
    output logic [31:0]            perf_reads,
    output logic [31:0]            perf_writes,
    output logic [31:0]            perf_stalls
`endif
);

    localparam int LAT    = (LATENCY > MEM_RSP_LATENCY_MAX) ? MEM_RSP_LATENCY_MAX :
                            ((LATENCY < 1) ? 1 : LATENCY);
    localparam int LINE_W = DATA_SIZE * 8;
    localparam int PAY_W  = TAG_WIDTH + LINE_W;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

    logic [LINE_W-1:0] mem_q [2**ADDR_WIDTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              wr_acc, rd_acc, rsp_hs;
    logic [PAY_W-1:0]  stage_pay, push_pay, rsp_pay;
    logic              push_vld;
    logic              unused_fifo_full, unused_fifo_empty;

    assign wr_acc = req_valid && req_ready_q && req_rw;
    assign rd_acc = req_valid && req_ready_q && !req_rw;
    assign rsp_hs = rsp_valid && rsp_ready;

    // Counting pipeline plus queue occupancy guarantees the queue can always absorb every in-flight read.
    always_comb begin
        cnt_d = cnt_q;
        if (rd_acc && !rsp_hs) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!rd_acc && rsp_hs) begin
            cnt_d = cnt_q - 1'b1;
        end
        req_ready_d = (cnt_d < CNT_W'(RSP_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < DATA_SIZE; b++) begin
                if (req_byteen[b]) begin
                    mem_q[req_addr][b*8 +: 8] <= req_data[b*8 +: 8];
                end
            end
        end
    end

    // Reading at acceptance sees every write committed on earlier edges.
    assign stage_pay = {req_tag, mem_q[req_addr]};

    generate
        if (LAT == 1) begin : g_lat1
            assign push_vld = rd_acc;
            assign push_pay = stage_pay;
        end else begin : g_pipe
            logic [LAT-2:0]   vld_q, vld_d;
            logic [PAY_W-1:0] pay_q [LAT-1];
            logic [PAY_W-1:0] pay_d [LAT-1];

            always_comb begin
                vld_d    = '0;
                vld_d[0] = rd_acc;
                pay_d[0] = stage_pay;
                for (int i = 1; i < LAT - 1; i++) begin
                    vld_d[i] = vld_q[i-1];
                    pay_d[i] = pay_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
                pay_q <= pay_d;
            end

            assign push_vld = vld_q[LAT-2];
            assign push_pay = pay_q[LAT-2];
        end
    endgenerate

    vx_mem_responder_rsp_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .reset    (reset),
        .s_tvalid (push_vld),
        .s_tdata  (push_pay),
        .m_tvalid (rsp_valid),
        .m_tdata  (rsp_pay),
        .m_tready (rsp_ready),
        .full     (unused_fifo_full),
        .empty    (unused_fifo_empty)
    );

    assign req_ready         = req_ready_q;
    assign {rsp_tag, rsp_data} = rsp_pay;

`ifdef MEM_RESPONDER_PERF_EN
    logic [31:0] perf_reads_q, perf_reads_d;
    logic [31:0] perf_writes_q, perf_writes_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_reads_d  = perf_reads_q + 32'(rd_acc);
        perf_writes_d = perf_writes_q + 32'(wr_acc);
        perf_stalls_d = perf_stalls_q + 32'(req_valid && !req_ready_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_reads_q  <= '0;
            perf_writes_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_reads_q  <= perf_reads_d;
            perf_writes_q <= perf_writes_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_reads  = perf_reads_q;
    assign perf_writes = perf_writes_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule
